uart_alu_interface: RTL
=======================

// Module: uart_alu_interface
//
// PURPOSE
//  Downstream consumer of the UART receiver's byte stream. Collects three received
//  bytes (operand A, operand B, opcode), drives them to the combinational ALU, then
//  hands the ALU result to the UART transmitter with a start/done handshake.
//  Sits between receiver (o_rx_data/o_rx_done) and transmitter (i_tx_start/o_tx_done).
//
// PARAMETERS
//  NB_DATA  8  width of received bytes, ALU operands and ALU result
//  NB_OP    6  opcode width; taken from i_rx_data[NB_OP-1:0], upper bits ignored
//
// PORTS
//  i_clock       in   1        system clock, all state on rising edge
//  i_reset_n     in   1        reset, asynchronous, active-low
//  i_rx_data     in   NB_DATA  byte from receiver, valid when i_rx_done=1
//  i_rx_done     in   1        1-cycle pulse: new byte on i_rx_data
//  i_alu_result  in   NB_DATA  combinational ALU result for o_alu_a/o_alu_b/o_alu_op
//  i_tx_done     in   1        1-cycle pulse: transmitter finished sending byte
//  o_alu_a       out  NB_DATA  registered operand A
//  o_alu_b       out  NB_DATA  registered operand B
//  o_alu_op      out  NB_OP    registered opcode
//  o_tx_data     out  NB_DATA  registered byte for transmitter
//  o_tx_start    out  1        1-cycle pulse: start transmission of o_tx_data
//  o_busy        out  1        1 in LAUNCH and WAIT_TX (new bytes not accepted)
//  o_rx_dropped  out  1        1-cycle pulse: byte arrived while busy, discarded
//
// BEHAVIOUR
//  - Reset (i_reset_n=0, async): state=WAIT_A; all outputs 0.
//  - All outputs registered; no combinational path input->output.
//  - One-hot FSM, 5 states:
//    WAIT_A : i_rx_done -> o_alu_a<=i_rx_data, go WAIT_B; else stay
//    WAIT_B : i_rx_done -> o_alu_b<=i_rx_data, go WAIT_OP; else stay
//    WAIT_OP: i_rx_done -> o_alu_op<=i_rx_data[NB_OP-1:0], go LAUNCH; else stay
//    LAUNCH : unconditional, one cycle; o_tx_data<=i_alu_result, o_tx_start<=1,
//             go WAIT_TX (ALU inputs stable for full LAUNCH cycle)
//    WAIT_TX: i_tx_done -> go WAIT_A; else stay
//    illegal/default -> WAIT_A
//  - Latency: opcode i_rx_done at edge n -> o_alu_op valid after n, o_tx_start=1
//    and o_tx_data valid after n+1; o_tx_start cleared after n+2 (exactly 1 cycle).
//  - o_alu_a/b/op and o_tx_data hold value until next overwrite; not cleared on
//    return to WAIT_A.
//  - o_busy registered: 1 exactly while state is LAUNCH or WAIT_TX.
//  - i_rx_done in LAUNCH or WAIT_TX: byte discarded, o_rx_dropped=1 next cycle,
//    no state/operand change.
//  - i_rx_done and i_tx_done same cycle in WAIT_TX: go WAIT_A, byte discarded,
//    o_rx_dropped pulses; next byte becomes operand A.
//  - i_tx_done outside WAIT_TX: ignored.
//  - Reset mid-sequence: partial operands lost, restart at WAIT_A.
//
// TESTING
//  1 rx 0x05,0x03,0x20 (ADD), ALU=A+B -> o_alu_a=05,b=03,op=20; one o_tx_start,
//    o_tx_data=0x08 two cycles after 3rd rx_done
//  2 after 1, pulse i_tx_done -> o_busy=0; rx 0xFF,0x01,0x20 -> o_tx_data=0x00 (wrap)
//  3 rx 0xC0 as opcode byte, NB_OP=6 -> o_alu_op=6'h00 (upper bits dropped)
//  4 rx_done during WAIT_TX -> o_rx_dropped 1 cycle, operands unchanged, no tx_start
//  5 rx_done and tx_done same cycle in WAIT_TX -> state WAIT_A, o_rx_dropped=1
//  6 assert i_reset_n=0 after 2 bytes, mid-cycle -> outputs 0 immediately; 3 new
//    bytes then give a complete correct transaction

Source files
------------

// File: rtl/uart_alu_interface.sv
// ---------------------------------------------------------------------------
// uart_alu_interface
//
// Purpose:
//   Sits between a UART receiver and a UART transmitter around a purely
//   combinational ALU. Three received bytes are collected in order:
//   operand A, operand B, then the opcode. The ALU result is then captured
//   and handed to the transmitter with a single-cycle start pulse. The block
//   stays busy until the transmitter reports completion.
//
// Handshake semantics (all pulses are one clock wide, sampled on the rising
// edge of i_clock):
//   i_rx_done  : i_rx_data carries a new byte this cycle. Accepted in
//                WAIT_A/WAIT_B/WAIT_OP, discarded (and flagged on
//                o_rx_dropped the next cycle) in LAUNCH/WAIT_TX.
//   o_tx_start : o_tx_data is valid and transmission should begin. Issued
//                exactly once per collected opcode.
//   i_tx_done  : transmitter finished; only meaningful in WAIT_TX, ignored
//                in every other state.
//
// Ports:
//   i_clock       in   1        system clock, rising edge
//   i_reset_n     in   1        asynchronous active-low reset
//   i_rx_data     in   NB_DATA  received byte, valid with i_rx_done
//   i_rx_done     in   1        new received byte pulse
//   i_alu_result  in   NB_DATA  combinational ALU result of o_alu_a/b/op
//   i_tx_done     in   1        transmitter finished pulse
//   o_alu_a       out  NB_DATA  registered operand A
//   o_alu_b       out  NB_DATA  registered operand B
//   o_alu_op      out  NB_OP    registered opcode (low NB_OP bits of byte)
//   o_tx_data     out  NB_DATA  registered byte for the transmitter
//   o_tx_start    out  1        transmit start pulse
//   o_busy        out  1        high while in LAUNCH or WAIT_TX
//   o_rx_dropped  out  1        pulse: a byte arrived while busy
// ---------------------------------------------------------------------------
module uart_alu_interface #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_rx_dropped
);

    // One-hot state encoding; any other pattern falls back to WAIT_A.
    typedef enum logic [4:0] {
        ST_WAIT_A  = 5'b00001,
        ST_WAIT_B  = 5'b00010,
        ST_WAIT_OP = 5'b00100,
        ST_LAUNCH  = 5'b01000,
        ST_WAIT_TX = 5'b10000
    } state_t;

    state_t             state_q,      state_d;
    logic [NB_DATA-1:0] alu_a_q,      alu_a_d;
    logic [NB_DATA-1:0] alu_b_q,      alu_b_d;
    logic [NB_OP-1:0]   alu_op_q,     alu_op_d;
    logic [NB_DATA-1:0] tx_data_q,    tx_data_d;
    logic               tx_start_q,   tx_start_d;
    logic               busy_q,       busy_d;
    logic               rx_dropped_q, rx_dropped_d;

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= ST_WAIT_A;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            busy_q       <= 1'b0;
            rx_dropped_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            busy_q       <= busy_d;
            rx_dropped_q <= rx_dropped_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        // Hold everything by default; pulses default low.
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        tx_data_d    = tx_data_q;
        tx_start_d   = 1'b0;
        rx_dropped_d = 1'b0;

        case (state_q)
            ST_WAIT_A: begin
                if (i_rx_done) begin
                    alu_a_d = i_rx_data;
                    state_d = ST_WAIT_B;
                end
            end

            ST_WAIT_B: begin
                if (i_rx_done) begin
                    alu_b_d = i_rx_data;
                    state_d = ST_WAIT_OP;
                end
            end

            ST_WAIT_OP: begin
                if (i_rx_done) begin
                    // Opcode lives in the low bits; upper bits are ignored.
                    alu_op_d = i_rx_data[NB_OP-1:0];
                    state_d  = ST_LAUNCH;
                end
            end

            ST_LAUNCH: begin
                // Operands were registered on the previous edge, so the ALU
                // output has had a full cycle to settle before capture.
                tx_data_d    = i_alu_result;
                tx_start_d   = 1'b1;
                rx_dropped_d = i_rx_done;
                state_d      = ST_WAIT_TX;
            end

            ST_WAIT_TX: begin
                // A byte arriving together with i_tx_done is still dropped;
                // the next byte after this cycle becomes operand A.
                rx_dropped_d = i_rx_done;
                if (i_tx_done) begin
                    state_d = ST_WAIT_A;
                end
            end

            default: begin
                state_d = ST_WAIT_A;
            end
        endcase

        // Registered busy flag tracks the state being entered so that it is
        // exactly aligned with LAUNCH/WAIT_TX occupancy.
        busy_d = (state_d == ST_LAUNCH) || (state_d == ST_WAIT_TX);
    end

    assign o_alu_a      = alu_a_q;
    assign o_alu_b      = alu_b_q;
    assign o_alu_op     = alu_op_q;
    assign o_tx_data    = tx_data_q;
    assign o_tx_start   = tx_start_q;
    assign o_busy       = busy_q;
    assign o_rx_dropped = rx_dropped_q;

endmodule
